// File: rtl/armv8_pkg.sv
// Shared definitions for the ARMv8 pipeline: memory-stage FSM encoding and
// data-memory sizing defaults.
package armv8_pkg;

    localparam int MEM_WORDS_DEFAULT = 128;
    localparam int MEM_IDX_W         = $clog2(MEM_WORDS_DEFAULT);

    typedef enum logic {
        MEM_RUN       = 1'b0,
        MEM_LOAD_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed 64-bit data memory with synchronous write and synchronous
// read on separate index ports; contents survive reset.
module data_memory
    import armv8_pkg::*;
#(
    parameter int WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(WORDS)-1:0] i_wrIdx,
    input  logic [63:0]              i_wrData,
    input  logic                     i_rdEn,
    input  logic [$clog2(WORDS)-1:0] i_rdIdx,
    output logic [63:0]              o_rdData
);

    logic [63:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrIdx] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdIdx];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: performs the data-memory access, resolves branches and
// drives the MEM/WB register. Loads take an extra cycle to collect read data.
module mem_stage
    import armv8_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ALUresult,
    input  logic [63:0] writeData,
    input  logic [63:0] PCbranch,
    input  logic        ALUzero,
    input  logic        control_MemRead,
    input  logic        control_MemWrite,
    input  logic        control_Branch,
    input  logic        control_UncondBranch,
    input  logic        control_RegWrite,
    input  logic        control_MemtoReg,
    input  logic [4:0]  writeReg,
    output logic        PCsrc,
    output logic [63:0] branchTarget,
    output logic        out_valid,
    output logic [63:0] readData,
    output logic [63:0] ALUresultOut,
    output logic [4:0]  writeRegOut,
    output logic        control_RegWriteOut,
    output logic        control_MemtoRegOut,
    output logic        memFault
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    mem_state_t r_state;

    logic             w_accept;
    logic             w_memOp;
    logic             w_fault;
    logic             w_doLoad;
    logic             w_doStore;
    logic [IDX_W-1:0] w_idx;
    logic [63:0]      w_rdData;

    assign in_ready = (r_state == MEM_RUN);
    assign w_accept = in_valid && in_ready;

    // Any address bit above the memory's byte span means out of range.
    assign w_memOp  = control_MemRead || control_MemWrite;
    assign w_fault  = w_memOp && ((ALUresult[2:0] != 3'b000)
                                  || (|ALUresult[63:IDX_W+3])
                                  || (control_MemRead && control_MemWrite));
    assign w_doLoad  = w_accept && control_MemRead && !control_MemWrite && !w_fault;
    assign w_doStore = w_accept && control_MemWrite && !control_MemRead && !w_fault;
    assign w_idx     = ALUresult[IDX_W+2:3];

    assign PCsrc        = w_accept && ((control_Branch && ALUzero) || control_UncondBranch);
    assign branchTarget = PCbranch;

    data_memory #(.WORDS(MEM_WORDS)) u_dataMemory (
        .clk      (clk),
        .i_wrEn   (w_doStore),
        .i_wrIdx  (w_idx),
        .i_wrData (writeData),
        .i_rdEn   (w_doLoad),
        .i_rdIdx  (w_idx),
        .o_rdData (w_rdData)
    );

    // A load captures its address-side fields at accept; read data and
    // out_valid land one edge later from the memory's read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= MEM_RUN;
            out_valid           <= 1'b0;
            readData            <= 64'd0;
            ALUresultOut        <= 64'd0;
            writeRegOut         <= 5'd0;
            control_RegWriteOut <= 1'b0;
            control_MemtoRegOut <= 1'b0;
            memFault            <= 1'b0;
        end else begin
            case (r_state)
                MEM_RUN: begin
                    if (w_accept) begin
                        out_valid    <= !w_doLoad;
                        ALUresultOut <= ALUresult;
                        writeRegOut  <= writeReg;
                        if (w_fault) begin
                            readData            <= 64'd0;
                            control_RegWriteOut <= 1'b0;
                            control_MemtoRegOut <= 1'b0;
                            memFault            <= 1'b1;
                        end else begin
                            control_RegWriteOut <= control_RegWrite;
                            control_MemtoRegOut <= control_MemtoReg;
                        end
                        if (w_doLoad) begin
                            r_state <= MEM_LOAD_WAIT;
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                MEM_LOAD_WAIT: begin
                    readData  <= w_rdData;
                    out_valid <= 1'b1;
                    r_state   <= MEM_RUN;
                end
                default: r_state <= MEM_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, compared against a behavioural model of the stage.
module tb_mem_stage;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ALUresult;
    logic [63:0] writeData;
    logic [63:0] PCbranch;
    logic        ALUzero;
    logic        control_MemRead;
    logic        control_MemWrite;
    logic        control_Branch;
    logic        control_UncondBranch;
    logic        control_RegWrite;
    logic        control_MemtoReg;
    logic [4:0]  writeReg;
    logic        PCsrc;
    logic [63:0] branchTarget;
    logic        out_valid;
    logic [63:0] readData;
    logic [63:0] ALUresultOut;
    logic [4:0]  writeRegOut;
    logic        control_RegWriteOut;
    logic        control_MemtoRegOut;
    logic        memFault;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the architecturally visible state.
    logic [63:0] mMem [WORDS];
    logic        mReady;
    logic        mPending;
    int          mPendIdx;
    logic        mValid;
    logic        mDefined;
    logic [63:0] mRead;
    logic [63:0] mAlu;
    logic [4:0]  mReg;
    logic        mRw;
    logic        mMtr;
    logic        mFault;

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(WORDS)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .ALUresult            (ALUresult),
        .writeData            (writeData),
        .PCbranch             (PCbranch),
        .ALUzero              (ALUzero),
        .control_MemRead      (control_MemRead),
        .control_MemWrite     (control_MemWrite),
        .control_Branch       (control_Branch),
        .control_UncondBranch (control_UncondBranch),
        .control_RegWrite     (control_RegWrite),
        .control_MemtoReg     (control_MemtoReg),
        .writeReg             (writeReg),
        .PCsrc                (PCsrc),
        .branchTarget         (branchTarget),
        .out_valid            (out_valid),
        .readData             (readData),
        .ALUresultOut         (ALUresultOut),
        .writeRegOut          (writeRegOut),
        .control_RegWriteOut  (control_RegWriteOut),
        .control_MemtoRegOut  (control_MemtoRegOut),
        .memFault             (memFault)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkRegistered(input string where);
        checkOutput({where, " out_valid"}, 64'(out_valid), 64'(mValid));
        checkOutput({where, " memFault"}, 64'(memFault), 64'(mFault));
        if (mDefined) begin
            checkOutput({where, " readData"}, readData, mRead);
            checkOutput({where, " ALUresultOut"}, ALUresultOut, mAlu);
            checkOutput({where, " writeRegOut"}, 64'(writeRegOut), 64'(mReg));
            checkOutput({where, " RegWriteOut"}, 64'(control_RegWriteOut), 64'(mRw));
            checkOutput({where, " MemtoRegOut"}, 64'(control_MemtoRegOut), 64'(mMtr));
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [63:0] alu, input logic [63:0] wd,
                                 input logic [63:0] pcb, input logic zero, input logic rd,
                                 input logic wr, input logic br, input logic unc,
                                 input logic rw, input logic mtr, input logic [4:0] dst);
        in_valid             = valid;
        ALUresult            = alu;
        writeData            = wd;
        PCbranch             = pcb;
        ALUzero              = zero;
        control_MemRead      = rd;
        control_MemWrite     = wr;
        control_Branch       = br;
        control_UncondBranch = unc;
        control_RegWrite     = rw;
        control_MemtoReg     = mtr;
        writeReg             = dst;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the
    // model by the stage's rules and compare the MEM/WB register.
    task automatic runCycle(output logic accepted);
        logic acc;
        logic isFault;
        @(negedge clk);
        acc = in_valid && mReady;
        checkOutput("in_ready", 64'(in_ready), 64'(mReady));
        checkOutput("PCsrc", 64'(PCsrc),
                    64'(acc && ((control_Branch && ALUzero) || control_UncondBranch)));
        if (in_valid) checkOutput("branchTarget", branchTarget, PCbranch);
        @(posedge clk);
        #1;
        if (mPending) begin
            mValid   = 1'b1;
            mRead    = mMem[mPendIdx];
            mPending = 1'b0;
            mReady   = 1'b1;
            mDefined = 1'b1;
        end else if (acc) begin
            isFault = (control_MemRead || control_MemWrite) &&
                      ((ALUresult % 8 != 0) || (ALUresult >= 64'(WORDS * 8)) ||
                       (control_MemRead && control_MemWrite));
            mAlu     = ALUresult;
            mReg     = writeReg;
            mDefined = 1'b1;
            mValid   = 1'b1;
            if (isFault) begin
                mFault = 1'b1;
                mRead  = 64'd0;
                mRw    = 1'b0;
                mMtr   = 1'b0;
            end else begin
                mRw  = control_RegWrite;
                mMtr = control_MemtoReg;
                if (control_MemWrite) begin
                    mMem[int'(ALUresult / 8)] = writeData;
                end else if (control_MemRead) begin
                    mPending = 1'b1;
                    mPendIdx = int'(ALUresult / 8);
                    mReady   = 1'b0;
                    mValid   = 1'b0;
                    mDefined = 1'b0;
                end
            end
        end else begin
            mValid = 1'b0;
        end
        checkRegistered("cycle");
        accepted = acc;
    endtask

    // Present an instruction and hold it until accepted (bounded).
    task automatic issue(input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pcb,
                         input logic zero, input logic rd, input logic wr, input logic br,
                         input logic unc, input logic rw, input logic mtr, input logic [4:0] dst);
        logic acc;
        applyStimulus(1'b1, alu, wd, pcb, zero, rd, wr, br, unc, rw, mtr, dst);
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) begin
            runCycle(acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("[TB] FAIL acceptTimeout: observed=not accepted expected=accepted within 4 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle();
        logic acc;
        applyStimulus(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        runCycle(acc);
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mReady   = 1'b1;
        mPending = 1'b0;
        mValid   = 1'b0;
        mDefined = 1'b1;
        mRead    = 64'd0;
        mAlu     = 64'd0;
        mReg     = 5'd0;
        mRw      = 1'b0;
        mMtr     = 1'b0;
        mFault   = 1'b0;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkRegistered("reset");
    endtask

    initial begin
        int kind;
        logic [63:0] addr;
        logic acc;
        $display("[TB] mem_stage bench start");
        applyStimulus(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        doReset();

        // Give every memory word a known value.
        for (int w = 0; w < WORDS; w++) begin
            issue(64'(w * 8), {$urandom, $urandom}, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b0, 5'd0);
        end

        // Store then immediate load of the same word.
        issue(64'h10, 64'hDEADBEEF_00000001, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        issue(64'h10, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
        idle();
        checkOutput("storeLoad readData", readData, 64'hDEADBEEF_00000001);
        checkOutput("storeLoad writeRegOut", 64'(writeRegOut), 64'd7);
        idle();

        // Branch resolution.
        issue(64'd0, 64'd0, 64'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        issue(64'd0, 64'd0, 64'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        issue(64'd0, 64'd0, 64'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);

        // Misaligned store leaves memory untouched and sets the sticky fault.
        issue(64'h13, 64'h1111_2222_3333_4444, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("misaligned memFault", 64'(memFault), 64'd1);
        issue(64'h10, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        idle();
        checkOutput("misaligned oldData", readData, 64'hDEADBEEF_00000001);

        // Out-of-range load: no stall, zero data, RegWrite dropped.
        doReset();
        issue(64'(WORDS * 8), 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        checkOutput("oor in_ready", 64'(in_ready), 64'd1);
        checkOutput("oor RegWriteOut", 64'(control_RegWriteOut), 64'd0);
        checkOutput("oor memFault", 64'(memFault), 64'd1);
        idle();

        // Reset while the load is waiting drops it; memory keeps its data.
        issue(64'h10, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
        doReset();
        issue(64'h10, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
        idle();
        checkOutput("postReset readData", readData, 64'hDEADBEEF_00000001);

        // Back-to-back ALU pass-through.
        for (int i = 1; i <= 4; i++) begin
            issue(64'(i), 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i));
            checkOutput("passThrough ALUresultOut", ALUresultOut, 64'(i));
            checkOutput("passThrough out_valid", 64'(out_valid), 64'd1);
        end

        // Random instruction mix.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset();
            kind = int'($urandom_range(0, 6));
            addr = 64'($urandom_range(0, WORDS - 1)) * 8;
            case (kind)
                0: issue({$urandom, $urandom}, 64'd0, 64'd0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
                         1'($urandom), 1'b0, 5'($urandom));
                1: issue(addr, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'($urandom));
                2: issue(addr, {$urandom, $urandom}, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b0, 5'($urandom));
                3: issue({$urandom, $urandom}, 64'd0, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0,
                         1'($urandom), 1'($urandom), 1'b0, 1'b0, 5'($urandom));
                4: issue(addr + 64'($urandom_range(1, 7)), {$urandom, $urandom}, 64'd0, 1'b0,
                         1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom));
                5: issue(64'(WORDS * 8) + {32'd0, $urandom}, 64'd0, 64'd0, 1'b0, 1'b1, 1'($urandom),
                         1'b0, 1'b0, 1'b1, 1'b1, 5'($urandom));
                default: begin
                    applyStimulus(1'b0, {$urandom, $urandom}, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
                    runCycle(acc);
                end
            endcase
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
